instr_encoder: RTL and testbench

Sequential MIPS instruction encoder, the inverse of the control/decode path. It accepts abstract operations (kind plus register and immediate fields) over a valid/ready handshake and assembles 32-bit instruction words. It buffers the words in a 2-entry FIFO and writes them to consecutive instruction-memory addresses. It loads test and boot programs into the processor's instruction memory. A SYSCALL operation terminates a program.

---
 rtl/mips_isa_pkg.sv | 27 ++
 rtl/sync_fifo2.sv | 44 ++++
 rtl/instr_encoder.sv | 107 ++++++++++
 tb/tb_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants, abstract operation kinds and field positions
package mips_isa_pkg;
  typedef enum logic [3:0] {
    K_LW, K_SW, K_J, K_JAL, K_BNE, K_XORI, K_ADDI, K_JR,
    K_ADD, K_SUB, K_SLT, K_SYSCALL, K_NOOP
  } op_kind_e;
  localparam logic [3:0] KIND_MAX = 4'd12;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
endpackage

// File: rtl/sync_fifo2.sv
// sync_fifo2: two-entry synchronous FIFO with flush and occupancy level
module sync_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [1:0]   level
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  assign dout  = mem_q[rp_q];
  assign full  = cnt_q == 2'd2;
  assign empty = cnt_q == 2'd0;
  assign level = cnt_q;
  // storage, pointers and occupancy; flush keeps stale data but empties the queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS words from abstract operations and streams them into instruction memory
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  function automatic logic [31:0] encode(input logic [3:0] k, input logic [4:0] s, t, d,
                                         input logic [15:0] i, input logic [25:0] g);
    logic [31:0] w;
    w = 32'h0;
    case (k)
      K_LW:      w = {OP_LW, s, t, i};
      K_SW:      w = {OP_SW, s, t, i};
      K_BNE:     w = {OP_BNE, s, t, i};
      K_XORI:    w = {OP_XORI, s, t, i};
      K_ADDI:    w = {OP_ADDI, s, t, i};
      K_J:       w = {OP_J, g};
      K_JAL:     w = {OP_JAL, g};
      K_JR:      w = {OP_RTYPE, s, 15'd0, FN_JR};
      K_ADD:     w = {OP_RTYPE, s, t, d, 5'd0, FN_ADD};
      K_SUB:     w = {OP_RTYPE, s, t, d, 5'd0, FN_SUB};
      K_SLT:     w = {OP_RTYPE, s, t, d, 5'd0, FN_SLT};
      K_SYSCALL: w = {26'd0, FN_SYSCALL};
      default:   w = 32'h0;
    endcase
    return w;
  endfunction
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              full, empty, push, pop, go;
  logic [1:0]        level;
  logic [31:0]       word;
  assign go        = start && (state_q == IDLE || state_q == DONE);
  assign op_ready  = state_q == RUN && !full;
  assign push      = op_valid && op_ready;
  assign imem_we   = !empty;
  assign pop       = imem_we && imem_ready;
  assign word      = encode(op_kind, rs, rt, rd, imm, target);
  assign imem_addr = addr_q;
  assign busy      = state_q == RUN || state_q == DRAIN;
  assign done      = state_q == DONE;
  assign err       = err_q;
  assign count     = count_q;
  sync_fifo2 #(.W(32)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(go), .push(push), .pop(pop), .din(word),
    .dout(imem_wdata), .full(full), .empty(empty), .level(level)
  );
  // next state: start restarts the program; DONE is entered as the last queued word leaves
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    if (go) begin
      state_d = RUN;
      addr_d  = BASE_A;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      if (state_q == RUN && push && op_kind == K_SYSCALL) state_d = DRAIN;
      if (state_q == DRAIN && (empty || (level == 2'd1 && pop))) state_d = DONE;
      if (pop) addr_d = addr_q + 1'b1;
      if (pop && count_q != CNT_MAX) count_d = count_q + 1'b1;
      if (push && op_kind > KIND_MAX) err_d = 1'b1;
    end
  end
  // state, write address, word count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= BASE_A;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scoreboard bench for instr_encoder
module tb_instr_encoder;
  localparam int AW = 2;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op_valid = 1'b0, imem_ready = 1'b1;
  logic [3:0] op_kind = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic op_ready, imem_we, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [3:0] k; logic [4:0] s, t, d; logic [15:0] i; logic [25:0] g; } op_t;
  wr_t sb[$];
  int wr_cyc[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] last_d = '0;
  logic hold_v = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [31:0] hold_d = '0;
  logic [AW-1:0] exp_addr = '0;
  wr_t e;

  instr_encoder #(.ADDR_W(AW), .BASE(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_valid(op_valid), .op_ready(op_ready),
    .op_kind(op_kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input op_t o);
    logic [31:0] w;
    case (o.k)
      4'd0:  w = {6'b100011, o.s, o.t, o.i};
      4'd1:  w = {6'b101011, o.s, o.t, o.i};
      4'd2:  w = {6'b000010, o.g};
      4'd3:  w = {6'b000011, o.g};
      4'd4:  w = {6'b000101, o.s, o.t, o.i};
      4'd5:  w = {6'b001110, o.s, o.t, o.i};
      4'd6:  w = {6'b001000, o.s, o.t, o.i};
      4'd7:  w = {6'b000000, o.s, 5'd0, 5'd0, 5'd0, 6'b001000};
      4'd8:  w = {6'b000000, o.s, o.t, o.d, 5'd0, 6'b100000};
      4'd9:  w = {6'b000000, o.s, o.t, o.d, 5'd0, 6'b100010};
      4'd10: w = {6'b000000, o.s, o.t, o.d, 5'd0, 6'b101010};
      4'd11: w = 32'h0000000C;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  // scoreboard: pop one expectation per completed write; check stall stability
  always @(negedge clk) begin
    if (rst_n) begin
      if (imem_we && hold_v) begin
        check("hold_addr", imem_addr, hold_a);
        check("hold_data", imem_wdata, hold_d);
      end
      hold_v = imem_we && !imem_ready;
      hold_a = imem_addr;
      hold_d = imem_wdata;
      if (imem_we && imem_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", imem_addr, imem_wdata);
        end else begin
          e = sb.pop_front();
          check("wr_addr", imem_addr, e.a);
          check("wr_data", imem_wdata, e.d);
          wr_cyc.push_back(cyc);
          last_d = imem_wdata;
        end
      end
    end else hold_v = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input op_t o);
    op_kind = o.k; rs = o.s; rt = o.t; rd = o.d; imm = o.i; target = o.g;
  endtask

  task automatic push_exp(input logic [31:0] w);
    sb.push_back({exp_addr, w});
    exp_addr++;
  endtask

  task automatic send(input op_t o, input logic [31:0] w);
    int n = 0;
    set_op(o);
    op_valid = 1'b1;
    while (!op_ready && n < 40) begin tick(); n++; end
    if (op_ready) begin
      push_exp(w);
      tick();
    end else check("op_ready_timeout", op_ready, 1);
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((imem_we || sb.size() != 0) && n < 50) begin tick(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin tick(); n++; end
    check("done_reached", done, 1);
    check("drain_queue", sb.size(), 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t ops[4];
    int idx;
    bit acc;
    op_t o;
    #2;
    check("rst_op_ready", op_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_count", count, 0);
    #10 rst_n = 1'b1;
    tick();
    check("idle_op_ready", op_ready, 0);
    check("idle_busy", busy, 0);
    // single ADD with junk in unused fields
    do_start();
    check("run_busy", busy, 1);
    check("run_op_ready", op_ready, 1);
    send('{4'd8, 5'd1, 5'd2, 5'd3, 16'hFFFF, 26'h3FFFFFF}, 32'h00221820);
    drain();
    check("add_count", count, 1);
    check("add_addr_next", imem_addr, 1);
    // LW then J back to back
    op_valid = 1'b0;
    o = '{4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0};
    send(o, 32'h0000000C);
    wait_done();
    do_start();
    send('{4'd0, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0}, 32'h8FA80004);
    send('{4'd2, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010}, 32'h08000010);
    drain();
    check("lw_j_consecutive", wr_cyc[$] - wr_cyc[$-1], 1);
    check("lw_j_count", count, 2);
    // backpressure: memory stalled for 5 cycles while 4 ops are offered
    ops[0] = '{4'd9, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h0};
    ops[1] = '{4'd10, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0};
    ops[2] = '{4'd5, 5'd10, 5'd11, 5'd0, 16'hBEEF, 26'h0};
    ops[3] = '{4'd1, 5'd12, 5'd13, 5'd0, 16'h0010, 26'h0};
    send(o, 32'h0000000C);
    wait_done();
    do_start();
    imem_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 5; i++) begin
      set_op(ops[idx]);
      op_valid = 1'b1;
      acc = op_ready;
      if (acc) push_exp(model(ops[idx]));
      tick();
      if (acc) idx++;
    end
    check("stall_accepted", idx, 2);
    check("stall_op_ready", op_ready, 0);
    check("stall_we", imem_we, 1);
    op_valid = 1'b0;
    imem_ready = 1'b1;
    send(ops[2], model(ops[2]));
    send(ops[3], model(ops[3]));
    drain();
    check("stall_count", count, 4);
    // ADDI, SYSCALL, then BNE offered and refused
    send(o, 32'h0000000C);
    wait_done();
    do_start();
    send('{4'd6, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0}, 32'h20220005);
    send('{4'd11, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF}, 32'h0000000C);
    set_op('{4'd4, 5'd1, 5'd2, 5'd0, 16'h0008, 26'h0});
    op_valid = 1'b1;
    check("drain_op_ready", op_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_not_done", done, 0);
    tick();
    check("sys_done", done, 1);
    check("sys_done_cycle", wr_cyc[$], cyc - 1);
    check("sys_last_word", last_d, 32'h0000000C);
    check("sys_count", count, 2);
    for (int i = 0; i < 3; i++) begin
      check("done_op_ready", op_ready, 0);
      tick();
    end
    op_valid = 1'b0;
    check("sys_no_extra", sb.size(), 0);
    // illegal kind: zero word, sticky err, cleared by start
    do_start();
    send('{4'd14, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h1555555}, 32'h0);
    check("illegal_err", err, 1);
    send('{4'd8, 5'd9, 5'd10, 5'd11, 16'h0, 26'h0}, 32'h012A5820);
    check("err_sticky", err, 1);
    send(o, 32'h0000000C);
    wait_done();
    check("err_after_done", err, 1);
    do_start();
    check("err_cleared", err, 0);
    check("restart_addr", imem_addr, 0);
    check("restart_count", count, 0);
    send('{4'd12, 5'd7, 5'd7, 5'd7, 16'h7777, 26'h0}, 32'h0);
    drain();
    // start while running is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_count", count, 1);
    check("start_ignored_addr", imem_addr, 1);
    send(o, 32'h0000000C);
    wait_done();
    // address wrap and count saturation with a 2-bit address
    do_start();
    send('{4'd1, 5'd3, 5'd4, 5'd0, 16'hFFFC, 26'h0}, 32'hAC64FFFC);
    send('{4'd3, 5'd0, 5'd0, 5'd0, 16'h0, 26'h2ABCDEF}, 32'h0EABCDEF);
    send('{4'd7, 5'd31, 5'd5, 5'd6, 16'h1111, 26'h0}, 32'h03E00008);
    send('{4'd5, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'h0}, 32'h384300FF);
    send('{4'd10, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0}, 32'h0022182A);
    drain();
    check("wrap_count_sat", count, 4);
    check("wrap_addr", imem_addr, 1);
    // asynchronous reset with a write pending
    imem_ready = 1'b0;
    send('{4'd0, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0}, 32'h8C220010);
    check("pre_rst_we", imem_we, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_op_ready", op_ready, 0);
    sb.delete();
    exp_addr = '0;
    #3 rst_n = 1'b1;
    imem_ready = 1'b1;
    tick();
    check("post_rst_we", imem_we, 0);
    check("post_rst_done", done, 0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
